// File: rtl/tqvp_pulse_gen_if.sv
// TinyQV register bus: the host drives address, write strobe and write data.
// The peripheral returns combinational read data for the current address.
interface tqvp_pulse_gen_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, data_write, data_in, input data_out);
  modport slave  (input address, data_write, data_in, output data_out);
endinterface

// File: rtl/tqvp_pulse_gen.sv
// Pulse-train generator: START to first pulse edge is 1 cycle, and reads are combinational.
// The bus has no backpressure. Defining PULSEGEN_EXT_TRIG_EN adds an external ui_in[0] trigger.
module tqvp_pulse_gen (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      ui_in,
  output logic [7:0]      uo_out,
  tqvp_pulse_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      state;
  logic        pol, cont, trig_arm, done;
  logic [15:0] count, rem;
  logic [7:0]  high_t, low_t, presc;
  logic [7:0]  presc_lat, presc_cnt, tick_cnt;

  logic ctrl_wr, wr_start, wr_stop, trig_fire, start, start_cont, busy;
  logic unused_inputs;

  function automatic logic [7:0] len_m1(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  assign ctrl_wr    = bus.data_write && (bus.address == 4'h0);
  assign wr_stop    = ctrl_wr && bus.data_in[1];
  assign wr_start   = ctrl_wr && bus.data_in[0] && !bus.data_in[1];
  assign start      = wr_start || trig_fire;
  assign start_cont = ctrl_wr ? bus.data_in[3] : cont;
  assign busy       = (state != IDLE);
  assign unused_inputs = ^ui_in;

`ifdef PULSEGEN_EXT_TRIG_EN
  logic trig_q1, trig_q2;
  // A CTRL write in the same cycle takes precedence over the pin.
  assign trig_fire = trig_arm && (state == IDLE) && trig_q1 && !trig_q2 && !ctrl_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q1  <= 1'b0;
      trig_q2  <= 1'b0;
      trig_arm <= 1'b0;
    end else begin
      trig_q1 <= ui_in[0];
      trig_q2 <= trig_q1;
      if (ctrl_wr)        trig_arm <= bus.data_in[4];
      else if (trig_fire) trig_arm <= 1'b0;
    end
  end
`else
  assign trig_fire = 1'b0;
  assign trig_arm  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pol       <= 1'b0;
      cont      <= 1'b0;
      done      <= 1'b0;
      count     <= 16'd0;
      rem       <= 16'd0;
      high_t    <= 8'd0;
      low_t     <= 8'd0;
      presc     <= 8'd0;
      presc_lat <= 8'd0;
      presc_cnt <= 8'd0;
      tick_cnt  <= 8'd0;
    end else begin
      if (bus.data_write) begin
        case (bus.address)
          4'h0: begin
            pol  <= bus.data_in[2];
            cont <= bus.data_in[3];
            done <= 1'b0;
          end
          4'h1:    count[7:0]  <= bus.data_in;
          4'h2:    count[15:8] <= bus.data_in;
          4'h3:    high_t      <= bus.data_in;
          4'h4:    low_t       <= bus.data_in;
          4'h5:    presc       <= bus.data_in;
          default: ;
        endcase
      end

      // Prescaler runs inside each tick; a phase ends when both counters are exhausted.
      case (state)
        HIGH, LOW: begin
          if (presc_cnt != 8'd0) begin
            presc_cnt <= presc_cnt - 8'd1;
          end else if (tick_cnt != 8'd0) begin
            presc_cnt <= presc_lat;
            tick_cnt  <= tick_cnt - 8'd1;
          end else if (state == HIGH) begin
            if (!cont && rem <= 16'd1) begin
              rem   <= 16'd0;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              if (!cont) rem <= rem - 16'd1;
              state     <= LOW;
              presc_cnt <= presc;
              presc_lat <= presc;
              tick_cnt  <= len_m1(low_t);
            end
          end else begin
            state     <= HIGH;
            presc_cnt <= presc;
            presc_lat <= presc;
            tick_cnt  <= len_m1(high_t);
          end
        end
        default: ;
      endcase

      if (wr_stop) begin
        state <= IDLE;
        done  <= 1'b0;
      end else if (start) begin
        if (count == 16'd0 && !start_cont) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          state     <= HIGH;
          rem       <= count;
          done      <= 1'b0;
          presc_cnt <= presc;
          presc_lat <= presc;
          tick_cnt  <= len_m1(high_t);
        end
      end
    end
  end

  assign uo_out = {4'b0000, done, busy, (state == HIGH) ^ pol, 1'b0};

  always_comb begin
    bus.data_out = 8'h00;
    case (bus.address)
      4'h0:    bus.data_out = {3'b000, trig_arm, cont, pol, done, busy};
      4'h1:    bus.data_out = count[7:0];
      4'h2:    bus.data_out = count[15:8];
      4'h3:    bus.data_out = high_t;
      4'h4:    bus.data_out = low_t;
      4'h5:    bus.data_out = presc;
      4'h6:    bus.data_out = rem[7:0];
      4'h7:    bus.data_out = rem[15:8];
      default: bus.data_out = 8'h00;
    endcase
  end
endmodule
